// File: rtl/uart_rx_pkg.sv
// UART receive front end: shared types and constants.
// Frame states, prescale limits and majority sample offsets.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_e;

  localparam int PRESCALE_MIN = 8;
  localparam int PRESCALE_MAX = 32;
  localparam int DATA_WIDTH   = 8;

  localparam int SAMPLE_OFS_EARLY = -1;
  localparam int SAMPLE_OFS_MID   = 0;
  localparam int SAMPLE_OFS_LATE  = 1;

  function automatic logic prescale_ok(int p);
    return (p >= PRESCALE_MIN) &&
           (p <= PRESCALE_MAX) &&
           (p % 2 == 0);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Link between the UART receive controller and the Rx parity checker.
// The controller is master; the checker returns a registered error flag.
interface uart_rx_frame_ctrl_if;

  logic [uart_rx_pkg::DATA_WIDTH-1:0] data_out;
  logic                               parity_bit_out;
  logic                               par_chk_en;
  logic                               parity_error;

  modport master (
    output data_out,
    output parity_bit_out,
    output par_chk_en,
    input  parity_error
  );

  modport slave (
    input  data_out,
    input  parity_bit_out,
    input  par_chk_en,
    output parity_error
  );

endinterface

// File: rtl/uart_rx_data_sampler.sv
// Three-point majority sampler centred on the middle of each bit.
// The late sample is taken live, so the vote resolves at P/2+1.
module uart_rx_data_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      active,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      rx_s,
  output logic                      sampled_bit,
  output logic                      sample_done
);
  import uart_rx_pkg::*;

  localparam int PW = PRESCALE_WIDTH;

  logic [1:0]    samp_q;
  logic [PW-1:0] half;
  logic [PW-1:0] pt_early;
  logic [PW-1:0] pt_mid;
  logic [PW-1:0] pt_late;

  assign half     = prescale >> 1;
  assign pt_early = PW'(int'(half) + SAMPLE_OFS_EARLY);
  assign pt_mid   = PW'(int'(half) + SAMPLE_OFS_MID);
  assign pt_late  = PW'(int'(half) + SAMPLE_OFS_LATE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      samp_q <= '0;
    end else if (active) begin
      if (edge_cnt == pt_early) samp_q[0] <= rx_s;
      if (edge_cnt == pt_mid)   samp_q[1] <= rx_s;
    end
  end

  assign sample_done = active && (edge_cnt == pt_late);

  assign sampled_bit = (samp_q[0] & samp_q[1]) |
                       (samp_q[0] & rx_s)      |
                       (samp_q[1] & rx_s);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start qualification, bit timing,
// LSB-first deserialisation and frame status strobes.
module uart_rx_frame_ctrl #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      parity_enable,
  uart_rx_frame_ctrl_if.master      chk,
  output logic                      data_valid,
  output logic                      stop_error,
  output logic                      start_glitch,
  output logic                      busy
);
  import uart_rx_pkg::*;

  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = $clog2(DATA_WIDTH);

  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s = sync_q[1];

  state_e                state_q, state_d;
  logic [PW-1:0]         edge_q, edge_d, edge_inc;
  logic [PW-1:0]         presc_q;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  stop_bad_q, stop_bad_d;
  logic                  par_en_q;
  logic                  latch;
  logic                  wrap;
  logic                  chk_en;
  logic                  active;
  logic                  sampled_bit;
  logic                  sample_done;

  assign wrap     = (edge_q == presc_q - PW'(1));
  assign edge_inc = wrap ? '0 : edge_q + PW'(1);
  assign active   = (state_q == START)  ||
                    (state_q == DATA)   ||
                    (state_q == PARITY) ||
                    (state_q == STOP);

  uart_rx_data_sampler #(
    .PRESCALE_WIDTH(PW)
  ) u_sampler (
    .clock      (clock),
    .reset      (reset),
    .active     (active),
    .edge_cnt   (edge_q),
    .prescale   (presc_q),
    .rx_s       (rx_s),
    .sampled_bit(sampled_bit),
    .sample_done(sample_done)
  );

  always_comb begin
    state_d      = state_q;
    edge_d       = edge_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    stop_bad_d   = stop_bad_q;
    latch        = 1'b0;
    chk_en       = 1'b0;
    start_glitch = 1'b0;
    data_valid   = 1'b0;
    stop_error   = 1'b0;
    unique case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_s) begin
          latch   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        edge_d = edge_inc;
        if (sample_done && sampled_bit) begin
          start_glitch = 1'b1;
          state_d      = IDLE;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        edge_d = edge_inc;
        if (sample_done)
          shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
        if (wrap) begin
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(DATA_WIDTH - 1))
            state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        edge_d = edge_inc;
        if (sample_done) par_d = sampled_bit;
        if (wrap) begin
          chk_en  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        edge_d = edge_inc;
        if (sample_done) begin
          stop_bad_d = !sampled_bit;
          state_d    = DONE;
        end
      end
      DONE: begin
        edge_d     = '0;
        stop_error = stop_bad_q;
        data_valid = !stop_bad_q &&
                     !(par_en_q && chk.parity_error);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      stop_bad_q <= 1'b0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_bad_q <= stop_bad_d;
      if (latch) begin
        presc_q  <= prescale;
        par_en_q <= parity_enable;
      end
    end
  end

  assign chk.data_out       = shreg_q;
  assign chk.parity_bit_out = par_q;
  assign chk.par_chk_en     = chk_en;
  assign busy               = (state_q != IDLE);

  // Prescale is only meaningful at the moment it is captured.
  a_prescale_legal: assert property (
    @(posedge clock) disable iff (!reset)
    latch |-> prescale_ok(int'(prescale))
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl with an even-parity checker model.
// Expected frame outcomes are queued at stimulus time and popped per frame.
module tb_uart_rx_frame_ctrl;

  logic       clock;
  logic       reset;
  logic       rx_in;
  logic [5:0] prescale;
  logic       parity_enable;
  logic       data_valid;
  logic       stop_error;
  logic       start_glitch;
  logic       busy;

  uart_rx_frame_ctrl_if par_if ();

  uart_rx_frame_ctrl #(
    .PRESCALE_WIDTH(6),
    .DATA_WIDTH    (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .parity_enable(parity_enable),
    .chk          (par_if),
    .data_valid   (data_valid),
    .stop_error   (stop_error),
    .start_glitch (start_glitch),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Even-parity checker: registered error, held until the next enable.
  always @(posedge clock or negedge reset) begin
    if (!reset)
      par_if.parity_error <= 1'b0;
    else if (par_if.par_chk_en)
      par_if.parity_error <= ^par_if.data_out ^ par_if.parity_bit_out;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit       glitch;
    bit [7:0] data;
    int       n_dv;
    int       n_se;
    int       n_pc;
    bit       par_on;
    bit       par_err;
  } exp_t;

  exp_t sb[$];

  task automatic push_frame(input bit [7:0] d, input bit par_on,
                            input bit par_bit, input bit stop_bit);
    exp_t e;
    e.glitch  = 1'b0;
    e.data    = d;
    e.par_on  = par_on;
    e.par_err = (^d) ^ par_bit;
    e.n_se    = stop_bit ? 0 : 1;
    e.n_dv    = (stop_bit && !(par_on && e.par_err)) ? 1 : 0;
    e.n_pc    = par_on ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic push_glitch();
    exp_t e;
    e.glitch  = 1'b1;
    e.data    = '0;
    e.par_on  = 1'b0;
    e.par_err = 1'b0;
    e.n_se    = 0;
    e.n_dv    = 0;
    e.n_pc    = 0;
    sb.push_back(e);
  endtask

  // Per-frame monitor: accumulate strobes while busy, judge on busy fall.
  int acc_dv, acc_se, acc_sg, acc_pc;
  bit prev_busy;

  always @(negedge clock) begin
    if (!reset) begin
      prev_busy = 1'b0;
      acc_dv = 0; acc_se = 0; acc_sg = 0; acc_pc = 0;
    end else begin
      if (busy) begin
        acc_dv += int'(data_valid);
        acc_se += int'(stop_error);
        acc_sg += int'(start_glitch);
        acc_pc += int'(par_if.par_chk_en);
      end
      if (prev_busy && !busy) begin
        check("sb_avail", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("glitch_cnt", acc_sg, e.glitch ? 1 : 0);
          check("valid_cnt", acc_dv, e.n_dv);
          check("stop_err_cnt", acc_se, e.n_se);
          check("par_chk_cnt", acc_pc, e.n_pc);
          if (!e.glitch) check("data_out", par_if.data_out, e.data);
          if (e.par_on) check("parity_err", par_if.parity_error, e.par_err);
        end
        acc_dv = 0; acc_se = 0; acc_sg = 0; acc_pc = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic drive_bit(input bit b, input int p);
    rx_in = b;
    repeat (p) @(negedge clock);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_frame(input bit [7:0] d, input bit par_on,
                             input bit par_bit, input bit stop_bit,
                             input int p);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (par_on) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    rx_in = 1'b1;
  endtask

  initial begin
    repeat (20000) @(negedge clock);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    rx_in         = 1'b1;
    prescale      = 6'd8;
    parity_enable = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_outs",
          {data_valid, stop_error, start_glitch, busy,
           par_if.par_chk_en, par_if.parity_bit_out, par_if.data_out}, 0);
    reset = 1'b1;
    idle(10);

    // 1: P=8, parity on, good parity and stop
    push_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    drive_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8);
    idle(24);

    // 2: parity bit wrong
    push_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    drive_frame(8'hA5, 1'b1, 1'b1, 1'b1, 8);
    idle(24);

    // 3: P=16, no parity, stop bit low; the low line then re-qualifies
    prescale      = 6'd16;
    parity_enable = 1'b0;
    push_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    push_glitch();
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16);
    idle(48);

    // 4: short low pulse on the line
    push_glitch();
    drive_bit(1'b0, 3);
    idle(48);
    check("idle_after_glitch", busy, 0);

    // 5: P=32 back-to-back; prescale disturbed mid-frame
    prescale = 6'd32;
    push_frame(8'h00, 1'b0, 1'b0, 1'b1);
    push_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    fork
      begin
        drive_frame(8'h00, 1'b0, 1'b0, 1'b1, 32);
        drive_frame(8'hFF, 1'b0, 1'b0, 1'b1, 32);
      end
      begin
        repeat (100) @(negedge clock);
        prescale = 6'd8;
        repeat (150) @(negedge clock);
        prescale = 6'd32;
      end
    join
    idle(64);

    // 6: P=8, reset during the 4th data bit, then a clean frame
    prescale = 6'd8;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    check("busy_mid", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outs",
          {data_valid, stop_error, start_glitch, busy,
           par_if.par_chk_en, par_if.parity_bit_out, par_if.data_out}, 0);
    idle(3);
    reset = 1'b1;
    idle(10);
    push_frame(8'h81, 1'b0, 1'b0, 1'b1);
    drive_frame(8'h81, 1'b0, 1'b0, 1'b1, 8);
    idle(24);

    for (int i = 0; i < 2000; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
